// File: rtl/string_stream_pkg.sv
// Shared types and helpers for the byte-to-bipolar bit serializer.
package string_stream_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FN_W   = 32;

    typedef enum logic [0:0] {
        SER_EMPTY,
        SER_SHIFT
    } ser_state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } byte_beat_t;

    // +1.0 / -1.0 in fixed point with frac_bits fraction bits; caller narrows to its width.
    function automatic logic signed [FN_W-1:0] bipolar_value(input bit b, input int unsigned frac_bits);
        logic signed [FN_W-1:0] one;
        one = 32'sd1 <<< frac_bits;
        return b ? one : -one;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with pointer-derived flags and first-word-fall-through read data.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count_c
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic             do_wr, do_rd;

    assign do_wr     = wr_en_i && !full_c;
    assign do_rd     = rd_en_i && !empty_c;
    assign count_c   = wptr_q - rptr_q;
    assign full_c    = (count_c == PTR_W'(DEPTH));
    assign empty_c   = (wptr_q == rptr_q);
    assign rd_data_c = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + PTR_W'(1);
            if (do_rd) rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/byte_bipolar_serializer.sv
// Byte stream in, one MSB-first bit per cycle out, with bipolar fixed-point value, frame index and last flag.
module byte_bipolar_serializer
    import string_stream_pkg::*;
#(
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned IDX_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W-1:0]       in_byte,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic signed [VAL_W-1:0] out_value,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    busy
);
    localparam int unsigned    CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned    J_W    = $clog2(BYTE_W);
    localparam logic [J_W-1:0] J_LAST = J_W'(BYTE_W - 1);

    byte_beat_t       wr_beat, rd_beat;
    logic             fifo_full, fifo_empty, fifo_empty_d;
    logic [CNT_W-1:0] fifo_count;
    logic             push, pop, xfer;

    ser_state_t          state_q, state_d;
    logic [J_W-1:0]      j_q, j_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic                last_q, last_d;

    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_bit_q, out_bit_d;
    logic signed [VAL_W-1:0] out_value_q, out_value_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;

    assign wr_beat = '{data: in_byte, last: in_last};
    assign push    = in_valid && in_ready_q;
    assign xfer    = out_valid_q && out_ready;

    sync_fifo #(
        .WIDTH ($bits(byte_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_data_i (wr_beat),
        .rd_en_i   (pop),
        .rd_data_c (rd_beat),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .count_c   (fifo_count)
    );

    // Look-ahead FIFO occupancy so in_ready and busy can be registered.
    always_comb begin
        in_ready_d   = 1'b1;
        fifo_empty_d = fifo_empty;
        if (push && !pop) begin
            in_ready_d   = (fifo_count != CNT_W'(FIFO_DEPTH - 1));
            fifo_empty_d = 1'b0;
        end else if (pop && !push) begin
            fifo_empty_d = (fifo_count == CNT_W'(1));
        end else begin
            in_ready_d = !fifo_full;
        end
    end

    // Shifter FSM plus registered-output next values.
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        pop         = 1'b0;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_value_d = '0;
        out_last_d  = 1'b0;
        out_index_d = out_index_q;
        busy_d      = 1'b0;

        case (state_q)
            SER_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = rd_beat.data;
                    last_d  = rd_beat.last;
                    j_d     = '0;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (xfer) begin
                    if (j_q != J_LAST) begin
                        j_d     = j_q + J_W'(1);
                        shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = rd_beat.data;
                        last_d  = rd_beat.last;
                        j_d     = '0;
                    end else begin
                        state_d = SER_EMPTY;
                    end
                end
            end
            default: state_d = SER_EMPTY;
        endcase

        out_valid_d = (state_d == SER_SHIFT);
        out_bit_d   = out_valid_d && shreg_d[BYTE_W-1];
        out_value_d = out_valid_d ? VAL_W'(bipolar_value(out_bit_d, FRAC_BITS)) : '0;
        out_last_d  = out_valid_d && last_d && (j_d == J_LAST);
        if (xfer) out_index_d = out_last_q ? '0 : out_index_q + IDX_W'(1);
        busy_d      = !fifo_empty_d || (state_d == SER_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SER_EMPTY;
            j_q         <= '0;
            shreg_q     <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            shreg_q     <= shreg_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_value = out_value_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_byte_bipolar_serializer.sv
// Directed bench with a bit-level scoreboard for the byte bipolar serializer (16-bit and 4-bit index builds).
module tb_byte_bipolar_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_bit, out_last, busy;
    logic [15:0] out_value;
    logic [15:0] out_index;

    logic        in_ready4, out_valid4, out_bit4, out_last4, busy4;
    logic [15:0] out_value4;
    logic [3:0]  out_index4;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] idx_exp;
    int          fbit;
    bit          rand_rdy;
    bit          wrap_watch;
    bit          held_v;
    logic        held_bit, held_last;
    logic [15:0] held_value, held_index;

    byte_bipolar_serializer #(
        .VAL_W(16), .FRAC_BITS(8), .FIFO_DEPTH(2), .IDX_W(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_value(out_value), .out_index(out_index),
        .out_last(out_last), .busy(busy)
    );

    byte_bipolar_serializer #(
        .VAL_W(16), .FRAC_BITS(8), .FIFO_DEPTH(2), .IDX_W(4)
    ) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
        .out_bit(out_bit4), .out_value(out_value4), .out_index(out_index4),
        .out_last(out_last4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden string-to-bits: MSB first, last flag only on bit 7 of a tagged byte.
    task automatic push_exp(input logic [7:0] b, input logic l);
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            e.b    = b[7-j];
            e.last = l && (j == 7);
            sb.push_back(e);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        int   n   = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        while (!acc && n < 200) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
        if (acc) push_exp(b, l);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_bit"},   32'(out_bit),   32'd0);
        check({tag, "_value"}, 32'(out_value), 32'd0);
        check({tag, "_index"}, 32'(out_index), 32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Random output backpressure, active only while enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: stall stability and scoreboard pop on every transfer.
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bit",   32'(out_bit),   32'(held_bit));
                check("hold_value", 32'(out_value), 32'(held_value));
                check("hold_index", 32'(out_index), 32'(held_index));
                check("hold_last",  32'(out_last),  32'(held_last));
            end
            if (out_valid && out_ready) begin
                check("spurious_bit", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("bit",   32'(out_bit),   32'(mon_e.b));
                    check("value", 32'(out_value), mon_e.b ? 32'h0000_0100 : 32'h0000_FF00);
                    check("index", 32'(out_index), 32'(idx_exp));
                    check("last",  32'(out_last),  32'(mon_e.last));
                    check("idx4_valid", 32'(out_valid4), 32'd1);
                    check("idx4_bit",   32'(out_bit4),   32'(mon_e.b));
                    check("idx4_value", 32'(out_value4), mon_e.b ? 32'h0000_0100 : 32'h0000_FF00);
                    check("idx4_index", 32'(out_index4), 32'(idx_exp[3:0]));
                    check("idx4_last",  32'(out_last4),  32'(mon_e.last));
                    if (wrap_watch && fbit == 16) check("wrap_index_bit16", 32'(out_index4), 32'd0);
                    if (wrap_watch && fbit == 23) begin
                        check("wrap_last_bit24",  32'(out_last4),  32'd1);
                        check("wrap_index_bit24", 32'(out_index4), 32'd7);
                    end
                    if (mon_e.last) begin
                        idx_exp = 16'd0;
                        fbit    = 0;
                    end else begin
                        idx_exp = idx_exp + 16'd1;
                        fbit++;
                    end
                end
            end
            held_v     = out_valid && !out_ready;
            held_bit   = out_bit;
            held_value = out_value;
            held_index = out_index;
            held_last  = out_last;
        end
    end

    initial begin
        int n;
        int cnt;
        int acc;
        logic rdy;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        rand_rdy   = 1'b0;
        wrap_watch = 1'b0;
        idx_exp    = 16'd0;
        fbit       = 0;
        held_v     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        check("in_ready_release", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // "A": two-edge latency then 8 bits
        push_byte(8'h41, 1'b1);
        check("a_latency_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("a_latency_edge2", 32'(out_valid), 32'd1);
        wait_drain();

        // "Hi" + "A" preloaded, then released: 24 contiguous bits
        out_ready = 1'b0;
        push_byte(8'h48, 1'b0);
        push_byte(8'h69, 1'b1);
        push_byte(8'h41, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt = 0;
        n   = 0;
        while (out_valid && n < 100) begin
            cnt++;
            @(posedge clk); #1;
            n++;
        end
        check("hi_a_contiguous_bits", 32'(cnt), 32'd24);
        wait_drain();

        // 32-byte frame under random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 32; k++) push_byte(8'($urandom_range(32, 126)), k == 31);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Full backpressure: FIFO plus shifter absorb FIFO_DEPTH+1 bytes
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_byte   = 8'hA5;
        for (int c = 0; c < 10; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                push_exp(in_byte, 1'b1);
                acc++;
                in_byte = in_byte + 8'h11;
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_in_ready4_low", 32'(in_ready4), 32'd0);
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_recover_within_8", 32'(n >= 1 && n <= 8), 32'd1);
        wait_drain();

        // Reset at bit 3 of byte 2, then a fresh 0xFF frame
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b1);
        n = 0;
        while (!(out_valid && out_index == 16'd19) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_index_19", 32'(out_index), 32'd19);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("midframe_reset");
        sb.delete();
        idx_exp = 16'd0;
        fbit    = 0;
        reset   = 1'b0;
        push_byte(8'hFF, 1'b1);
        wait_drain();

        // 4-bit index build: wrap at bit 16, last at index 7 on bit 24
        wrap_watch = 1'b1;
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        push_byte(8'h56, 1'b1);
        wait_drain();
        wrap_watch = 1'b0;
        check("idx4_busy_idle", 32'(busy4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
